// File: rtl/axi_read_arbiter.sv
// Read-channel controller for the 2-master / 2-slave AXI interconnect:
// round-robin AR arbitration, slave decode, phase sequencing and a DECERR default slave.
module axi_read_arbiter #(
    parameter logic [15:0] S0_HI = 16'h0000,
    parameter logic [15:0] S1_HI = 16'h0001
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic        ARVALID_M0,
    input  logic        ARVALID_M1,
    input  logic [31:0] ARADDR_M0,
    input  logic [31:0] ARADDR_M1,
    input  logic [3:0]  ARID_M0,
    input  logic [3:0]  ARID_M1,
    input  logic [3:0]  ARLEN_M0,
    input  logic [3:0]  ARLEN_M1,
    input  logic        RREADY_M0,
    input  logic        RREADY_M1,
    input  logic        ARREADY_S0,
    input  logic        ARREADY_S1,
    input  logic        RVALID_S0,
    input  logic        RVALID_S1,
    input  logic        RLAST_S0,
    input  logic        RLAST_S1,
    output logic [3:0]  CS_R,
    output logic [3:0]  NS_R,
    output logic [1:0]  AR_SEL,
    output logic        DS_ARREADY,
    output logic        DS_RVALID,
    output logic        DS_RLAST,
    output logic [1:0]  DS_RRESP,
    output logic [3:0]  DS_RID
);
    typedef enum logic [3:0] {
        IDLE    = 4'h0,
        RA_M1   = 4'h1,
        RD_M1S0 = 4'h2,
        RD_M1S1 = 4'h3,
        RA_M0   = 4'h4,
        RD_M0S0 = 4'h5,
        RD_M0S1 = 4'h6,
        DEF_SLV = 4'hD
    } state_t;

    state_t      cs_r;
    state_t      ns_s;
    logic        last_grant_r;   // 0: M0 granted last, 1: M1
    logic [4:0]  ds_cnt_r;
    logic [3:0]  ds_rid_r;
    logic        addr_m1_s;
    logic        ar_valid_s;
    logic        ar_ready_s;
    logic        ds_rready_s;
    logic [15:0] addr_hi_s;
    logic [3:0]  ar_len_s;
    logic [3:0]  ar_id_s;
    logic [1:0]  dec_sel_s;
    logic [1:0]  ar_sel_s;
    logic        ds_arready_s;
    logic        unused_addr_s;

    function automatic logic [1:0] decode_slave(input logic [15:0] hi);
        if (hi == S0_HI) begin
            return 2'b00;
        end else if (hi == S1_HI) begin
            return 2'b01;
        end else begin
            return 2'b10;
        end
    endfunction

    // Only the upper address half takes part in decoding
    assign unused_addr_s = ^{ARADDR_M0[15:0], ARADDR_M1[15:0]};

    assign addr_m1_s   = (cs_r == RA_M1);
    assign addr_hi_s   = addr_m1_s ? ARADDR_M1[31:16] : ARADDR_M0[31:16];
    assign ar_valid_s  = addr_m1_s ? ARVALID_M1 : ARVALID_M0;
    assign ar_len_s    = addr_m1_s ? ARLEN_M1 : ARLEN_M0;
    assign ar_id_s     = addr_m1_s ? ARID_M1 : ARID_M0;
    assign dec_sel_s   = decode_slave(addr_hi_s);
    assign ar_ready_s  = (dec_sel_s == 2'b01) ? ARREADY_S1 : ARREADY_S0;
    assign ds_rready_s = last_grant_r ? RREADY_M1 : RREADY_M0;

    // Next-state, AR mux select and default-slave address ready
    always_comb begin
        ns_s         = cs_r;
        ar_sel_s     = 2'b11;
        ds_arready_s = 1'b0;
        case (cs_r)
            IDLE: begin
                if (ARVALID_M0 && ARVALID_M1) begin
                    ns_s = last_grant_r ? RA_M0 : RA_M1;
                end else if (ARVALID_M0) begin
                    ns_s = RA_M0;
                end else if (ARVALID_M1) begin
                    ns_s = RA_M1;
                end else begin
                    ns_s = IDLE;
                end
            end
            RA_M0, RA_M1: begin
                ar_sel_s = dec_sel_s;
                if (dec_sel_s == 2'b10) begin
                    ds_arready_s = ar_valid_s;
                    ns_s         = ar_valid_s ? DEF_SLV : cs_r;
                end else if (ar_valid_s && ar_ready_s) begin
                    if (addr_m1_s) begin
                        ns_s = (dec_sel_s == 2'b01) ? RD_M1S1 : RD_M1S0;
                    end else begin
                        ns_s = (dec_sel_s == 2'b01) ? RD_M0S1 : RD_M0S0;
                    end
                end else begin
                    ns_s = cs_r;
                end
            end
            RD_M0S0: ns_s = (RVALID_S0 && RREADY_M0 && RLAST_S0) ? IDLE : cs_r;
            RD_M0S1: ns_s = (RVALID_S1 && RREADY_M0 && RLAST_S1) ? IDLE : cs_r;
            RD_M1S0: ns_s = (RVALID_S0 && RREADY_M1 && RLAST_S0) ? IDLE : cs_r;
            RD_M1S1: ns_s = (RVALID_S1 && RREADY_M1 && RLAST_S1) ? IDLE : cs_r;
            DEF_SLV: ns_s = (ds_rready_s && (ds_cnt_r == 5'd1)) ? IDLE : cs_r;
            default: ns_s = IDLE;
        endcase
    end

    // State, round-robin pointer and default-slave burst bookkeeping
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            cs_r         <= IDLE;
            last_grant_r <= 1'b1;
            ds_cnt_r     <= 5'd0;
            ds_rid_r     <= 4'd0;
        end else begin
            cs_r <= ns_s;
            if ((cs_r == IDLE) && (ns_s == RA_M0)) begin
                last_grant_r <= 1'b0;
            end else if ((cs_r == IDLE) && (ns_s == RA_M1)) begin
                last_grant_r <= 1'b1;
            end else begin
                last_grant_r <= last_grant_r;
            end
            if (ds_arready_s) begin
                ds_cnt_r <= {1'b0, ar_len_s} + 5'd1;
                ds_rid_r <= ar_id_s;
            end else if ((cs_r == DEF_SLV) && ds_rready_s) begin
                ds_cnt_r <= ds_cnt_r - 5'd1;
                ds_rid_r <= ds_rid_r;
            end else begin
                ds_cnt_r <= ds_cnt_r;
                ds_rid_r <= ds_rid_r;
            end
        end
    end

    assign CS_R       = cs_r;
    assign NS_R       = ns_s;
    assign AR_SEL     = ar_sel_s;
    assign DS_ARREADY = ds_arready_s;
    assign DS_RVALID  = (cs_r == DEF_SLV);
    assign DS_RLAST   = (cs_r == DEF_SLV) && (ds_cnt_r == 5'd1);
    assign DS_RRESP   = (cs_r == DEF_SLV) ? 2'b11 : 2'b00;
    assign DS_RID     = ds_rid_r;
endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: a transaction-level model checked every
// cycle, plus hand-computed literal expectations for each scenario.
module tb_axi_read_arbiter;
    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        ARVALID_M0, ARVALID_M1;
    logic [31:0] ARADDR_M0, ARADDR_M1;
    logic [3:0]  ARID_M0, ARID_M1, ARLEN_M0, ARLEN_M1;
    logic        RREADY_M0, RREADY_M1;
    logic        ARREADY_S0, ARREADY_S1, RVALID_S0, RVALID_S1, RLAST_S0, RLAST_S1;
    logic [3:0]  CS_R, NS_R, DS_RID;
    logic [1:0]  AR_SEL, DS_RRESP;
    logic        DS_ARREADY, DS_RVALID, DS_RLAST;

    int checks = 0;
    int errors = 0;
    int t2_cs[12] = '{0, 4, 5, 0, 1, 2, 0, 4, 5, 0, 1, 2};
    int t3_rr[5]  = '{1, 0, 1, 1, 1};

    // model: phase 0 idle, 1 address, 2 data, 3 default slave
    int m_ph, m_mst, m_tgt, m_last, m_cnt, m_id;

    axi_read_arbiter dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .ARVALID_M0(ARVALID_M0), .ARVALID_M1(ARVALID_M1),
        .ARADDR_M0(ARADDR_M0), .ARADDR_M1(ARADDR_M1),
        .ARID_M0(ARID_M0), .ARID_M1(ARID_M1),
        .ARLEN_M0(ARLEN_M0), .ARLEN_M1(ARLEN_M1),
        .RREADY_M0(RREADY_M0), .RREADY_M1(RREADY_M1),
        .ARREADY_S0(ARREADY_S0), .ARREADY_S1(ARREADY_S1),
        .RVALID_S0(RVALID_S0), .RVALID_S1(RVALID_S1),
        .RLAST_S0(RLAST_S0), .RLAST_S1(RLAST_S1),
        .CS_R(CS_R), .NS_R(NS_R), .AR_SEL(AR_SEL),
        .DS_ARREADY(DS_ARREADY), .DS_RVALID(DS_RVALID), .DS_RLAST(DS_RLAST),
        .DS_RRESP(DS_RRESP), .DS_RID(DS_RID)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int dec(input logic [31:0] a);
        if (a[31:16] == 16'h0000) return 0;
        if (a[31:16] == 16'h0001) return 1;
        return 2;
    endfunction

    function automatic int code(input int ph, input int mst, input int tgt);
        case (ph)
            0:       return 0;
            1:       return (mst == 0) ? 4 : 1;
            2:       return ((mst == 0) ? 5 : 2) + tgt;
            default: return 13;
        endcase
    endfunction

    // Every-cycle comparison against the model, then advance the model
    always @(negedge ACLK) begin
        logic [31:0] ad;
        logic        av, rr, ardy, rdone;
        int          t, n_ph, n_mst, n_tgt, n_last, n_cnt, n_id;
        if (ARESET) begin
            m_ph = 0; m_mst = 0; m_tgt = 0; m_last = 1; m_cnt = 0; m_id = 0;
        end else begin
            ad    = (m_mst == 1) ? ARADDR_M1 : ARADDR_M0;
            av    = (m_mst == 1) ? ARVALID_M1 : ARVALID_M0;
            rr    = (m_mst == 1) ? RREADY_M1 : RREADY_M0;
            t     = (m_ph == 1) ? dec(ad) : m_tgt;
            ardy  = (t == 1) ? ARREADY_S1 : ARREADY_S0;
            rdone = (t == 1) ? (RVALID_S1 && RLAST_S1) : (RVALID_S0 && RLAST_S0);
            check("cs", 32'(CS_R), code(m_ph, m_mst, m_tgt));
            check("ar_sel", 32'(AR_SEL), (m_ph == 1) ? t : 3);
            check("ds_arready", 32'(DS_ARREADY), (m_ph == 1 && t == 2 && av) ? 1 : 0);
            check("ds_rvalid", 32'(DS_RVALID), (m_ph == 3) ? 1 : 0);
            check("ds_rlast", 32'(DS_RLAST), (m_ph == 3 && m_cnt == 1) ? 1 : 0);
            check("ds_rresp", 32'(DS_RRESP), (m_ph == 3) ? 3 : 0);
            check("ds_rid", 32'(DS_RID), m_id);
            n_ph = m_ph; n_mst = m_mst; n_tgt = m_tgt; n_last = m_last; n_cnt = m_cnt; n_id = m_id;
            case (m_ph)
                0: if (ARVALID_M0 || ARVALID_M1) begin
                    n_mst  = (ARVALID_M0 && ARVALID_M1) ? 1 - m_last : (ARVALID_M1 ? 1 : 0);
                    n_ph   = 1;
                    n_last = n_mst;
                end
                1: if (av) begin
                    if (t == 2) begin
                        n_ph  = 3;
                        n_cnt = ((m_mst == 1) ? int'(ARLEN_M1) : int'(ARLEN_M0)) + 1;
                        n_id  = (m_mst == 1) ? int'(ARID_M1) : int'(ARID_M0);
                    end else if (ardy) begin
                        n_ph  = 2;
                        n_tgt = t;
                    end
                end
                2: if (rr && rdone) n_ph = 0;
                default: if (rr) begin
                    n_cnt = m_cnt - 1;
                    if (n_cnt == 0) n_ph = 0;
                end
            endcase
            check("ns", 32'(NS_R), code(n_ph, n_mst, n_tgt));
            m_ph = n_ph; m_mst = n_mst; m_tgt = n_tgt; m_last = n_last; m_cnt = n_cnt; m_id = n_id;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge ACLK);
        #1;
    endtask

    task automatic clr();
        ARVALID_M0 = 1'b0; ARVALID_M1 = 1'b0; ARADDR_M0 = 32'h0; ARADDR_M1 = 32'h0;
        ARID_M0 = 4'h0; ARID_M1 = 4'h0; ARLEN_M0 = 4'h0; ARLEN_M1 = 4'h0;
        RREADY_M0 = 1'b0; RREADY_M1 = 1'b0; ARREADY_S0 = 1'b0; ARREADY_S1 = 1'b0;
        RVALID_S0 = 1'b0; RVALID_S1 = 1'b0; RLAST_S0 = 1'b0; RLAST_S1 = 1'b0;
    endtask

    initial begin
        clr();
        cyc(2);
        @(negedge ACLK);
        check("rst_cs", 32'(CS_R), 0);
        check("rst_ar_sel", 32'(AR_SEL), 3);
        check("rst_ds_rvalid", 32'(DS_RVALID), 0);
        check("rst_ds_rid", 32'(DS_RID), 0);
        cyc(1); ARESET = 1'b0;

        // single-beat M0 read from S0
        ARVALID_M0 = 1'b1; ARADDR_M0 = 32'h0000_0040; ARREADY_S0 = 1'b1;
        @(negedge ACLK); check("t1_ns_idle", 32'(NS_R), 4);
        cyc(1); @(negedge ACLK); check("t1_cs_addr", 32'(CS_R), 4); check("t1_ar_sel", 32'(AR_SEL), 0);
        cyc(1); clr(); RVALID_S0 = 1'b1; RLAST_S0 = 1'b1; RREADY_M0 = 1'b1;
        @(negedge ACLK); check("t1_cs_data", 32'(CS_R), 5); check("t1_ar_sel_data", 32'(AR_SEL), 3);
        cyc(1); clr();
        @(negedge ACLK); check("t1_cs_end", 32'(CS_R), 0);

        // round-robin with both masters requesting continuously
        cyc(1); ARESET = 1'b1; cyc(1); ARESET = 1'b0;
        ARVALID_M0 = 1'b1; ARVALID_M1 = 1'b1; ARADDR_M0 = 32'h0000_0100; ARADDR_M1 = 32'h0000_0200;
        ARREADY_S0 = 1'b1; RVALID_S0 = 1'b1; RLAST_S0 = 1'b1; RREADY_M0 = 1'b1; RREADY_M1 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge ACLK); check("t2_cs", 32'(CS_R), t2_cs[i]);
        end
        cyc(1); clr();

        // M1 four-beat read from S1 with a stalled beat
        ARVALID_M1 = 1'b1; ARADDR_M1 = 32'h0001_0010; ARLEN_M1 = 4'd3; ARREADY_S1 = 1'b1;
        cyc(1); @(negedge ACLK); check("t3_cs_addr", 32'(CS_R), 1); check("t3_ar_sel", 32'(AR_SEL), 1);
        cyc(1); clr(); RVALID_S1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            RREADY_M1 = (t3_rr[i] == 1); RLAST_S1 = (i == 4);
            @(negedge ACLK); check("t3_cs_data", 32'(CS_R), 3);
            cyc(1);
        end
        clr();
        @(negedge ACLK); check("t3_cs_end", 32'(CS_R), 0);

        // M1 unmapped read answered by the default slave
        cyc(1); ARVALID_M1 = 1'b1; ARADDR_M1 = 32'h0003_0000; ARLEN_M1 = 4'd2; ARID_M1 = 4'h5;
        cyc(1); @(negedge ACLK);
        check("t4_ar_sel", 32'(AR_SEL), 2); check("t4_ds_arready", 32'(DS_ARREADY), 1); check("t4_ns", 32'(NS_R), 13);
        cyc(1); clr(); RREADY_M1 = 1'b1;
        for (int b = 0; b < 3; b++) begin
            @(negedge ACLK);
            check("t4_cs", 32'(CS_R), 13); check("t4_rvalid", 32'(DS_RVALID), 1);
            check("t4_rresp", 32'(DS_RRESP), 3); check("t4_rid", 32'(DS_RID), 5);
            check("t4_rlast", 32'(DS_RLAST), (b == 2) ? 1 : 0);
        end
        cyc(1); clr();
        @(negedge ACLK); check("t4_cs_end", 32'(CS_R), 0); check("t4_rvalid_end", 32'(DS_RVALID), 0);

        // M0 held in address phase while M1 pulses its request
        cyc(1); ARVALID_M0 = 1'b1; ARADDR_M0 = 32'h0001_0000;
        cyc(1);
        for (int i = 0; i < 5; i++) begin
            ARVALID_M1 = (i % 2 == 0);
            @(negedge ACLK); check("t5_cs_hold", 32'(CS_R), 4); check("t5_ar_sel", 32'(AR_SEL), 1);
            cyc(1);
        end
        ARVALID_M1 = 1'b0; ARREADY_S1 = 1'b1;
        @(negedge ACLK); check("t5_ns", 32'(NS_R), 6);
        cyc(1); clr(); RVALID_S1 = 1'b1; RLAST_S1 = 1'b1; RREADY_M0 = 1'b1;
        @(negedge ACLK); check("t5_cs_data", 32'(CS_R), 6);
        cyc(1); clr();
        @(negedge ACLK); check("t5_cs_end", 32'(CS_R), 0);

        // asynchronous reset in the middle of a default-slave burst
        cyc(1); ARVALID_M0 = 1'b1; ARADDR_M0 = 32'h0005_0000; ARLEN_M0 = 4'd3; ARID_M0 = 4'h9;
        cyc(2); clr(); RREADY_M0 = 1'b1;
        @(negedge ACLK); check("t6_rid", 32'(DS_RID), 9); check("t6_rlast", 32'(DS_RLAST), 0);
        @(posedge ACLK); #3;
        ARESET = 1'b1; #1;
        check("t6_rst_cs", 32'(CS_R), 0); check("t6_rst_rvalid", 32'(DS_RVALID), 0);
        check("t6_rst_rid", 32'(DS_RID), 0);
        cyc(2); clr(); ARESET = 1'b0;
        ARVALID_M0 = 1'b1; ARADDR_M0 = 32'h0000_0040; ARREADY_S0 = 1'b1;
        cyc(1); @(negedge ACLK); check("t6_cs_addr", 32'(CS_R), 4);
        cyc(1); clr(); RVALID_S0 = 1'b1; RLAST_S0 = 1'b1; RREADY_M0 = 1'b1;
        @(negedge ACLK); check("t6_cs_data", 32'(CS_R), 5);
        cyc(1); clr();
        @(negedge ACLK); check("t6_cs_end", 32'(CS_R), 0);

        cyc(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_read_arbiter.md
Name: axi_read_arbiter

Overview:
- Read-channel controller for the two-master (M0 instruction fetch, M1 data), two-slave (S0, S1) AXI interconnect.
- Arbitrates AR requests round-robin and decodes the target slave.
- Sequences the address and data phases through state register CS_R and next-state NS_R; these drive the master-to-slave read mux selects.
- Contains the default slave, which answers unmapped reads with DECERR bursts.

Parameters:
S0_HI, 16'h0000, ARADDR[31:16] value mapped to S0
S1_HI, 16'h0001, ARADDR[31:16] value mapped to S1

Ports:
ACLK  in  1  clock
ARESET  in  1  asynchronous reset, active-high
ARVALID_M0 / ARVALID_M1  in  1  master read-address valid
ARADDR_M0 / ARADDR_M1  in  32  master read address
ARID_M0 / ARID_M1  in  4  master read ID
ARLEN_M0 / ARLEN_M1  in  4  master burst length minus 1
RREADY_M0 / RREADY_M1  in  1  master read-data ready
ARREADY_S0 / ARREADY_S1  in  1  slave address ready
RVALID_S0 / RVALID_S1  in  1  slave read-data valid
RLAST_S0 / RLAST_S1  in  1  slave last beat
CS_R  out  4  current read state (registered)
NS_R  out  4  next read state (combinational)
AR_SEL  out  2  AR target: 00 S0, 01 S1, 10 default slave, 11 none
DS_ARREADY  out  1  default-slave address ready
DS_RVALID  out  1  default-slave read valid
DS_RLAST  out  1  default-slave last beat
DS_RRESP  out  2  default-slave response
DS_RID  out  4  default-slave read ID

Behaviour:
- State codes: IDLE 4'h0, ReadAddr_M1 4'h1, ReadData_M1S0 4'h2, ReadData_M1S1 4'h3, ReadAddr_M0 4'h4, ReadData_M0S0 4'h5, ReadData_M0S1 4'h6, Default_Slave 4'hD. No other codes are ever produced.
- Reset (async, immediate, including mid-burst):
  - CS_R=IDLE, last_grant=M1, so M0 wins the first tie.
  - DS beat counter=0, DS_RID=0.
  - All DS_* outputs 0; AR_SEL=11.
- CS_R <= NS_R on every ACLK rising edge.
- IDLE:
  - Only ARVALID_M0 set -> ReadAddr_M0.
  - Only ARVALID_M1 set -> ReadAddr_M1.
  - Both set -> the master not equal to last_grant.
  - last_grant updates on entry to a ReadAddr state.
  - Neither set -> stay in IDLE.
- ReadAddr_Mx:
  - Decode ARADDR_Mx[31:16]: S0_HI -> AR_SEL=00; S1_HI -> 01; else 10.
  - AR_SEL=11 in every other state.
  - ARVALID_Mx && ARREADY_Sy (y decoded) -> ReadData_MxSy.
  - AR_SEL=10: DS_ARREADY=ARVALID_Mx, combinationally, in the same cycle. On handshake, latch ARLEN_Mx+1 into a 5-bit beat counter and ARID_Mx into DS_RID, then go to Default_Slave.
  - No handshake -> hold the state. The master must keep ARVALID and ARADDR stable; the arbiter never withdraws a grant.
- ReadData_MxSy: RVALID_Sy && RREADY_Mx && RLAST_Sy -> IDLE; otherwise hold. Beats without RLAST keep the state.
- Default_Slave:
  - DS_RVALID=1 and DS_RRESP=2'b11 (DECERR).
  - DS_RLAST=1 when counter==1.
  - RREADY_Mx decrements the counter; the master is M0 or M1, from last_grant.
  - RREADY_Mx with counter==1 -> IDLE, counter=0.
  - ARLEN=15 yields 16 beats; there is no wrap.
- Outside Default_Slave: DS_RVALID=0, DS_RLAST=0, DS_RRESP=2'b00.
- Only one read transaction is outstanding at any time. A request arriving during a burst waits in its master until IDLE.
- The arbitration decision in IDLE is made combinationally. Latency from ARVALID (with the arbiter idle) to CS_R=ReadAddr is 1 cycle.
- Minimum single-beat transaction is 3 cycles: IDLE -> ReadAddr -> ReadData -> IDLE.

Test Plan:
- Reset, then ARVALID_M0=1, ARADDR_M0=0x0000_0040, ARREADY_S0=1 at the next edge -> CS_R 0 -> 4 -> 5. Then RVALID_S0=RLAST_S0=RREADY_M0=1 -> CS_R=0, AR_SEL=11 throughout the data phase.
- ARVALID_M0 and ARVALID_M1 held high across 4 back-to-back single-beat transactions -> grants M0, M1, M0, M1, with CS_R visiting 4, 1, 4, 1.
- M1 reads 0x0001_0010 with ARLEN=3 and RLAST_S1 only on beat 4; RREADY_M1 toggled 1,0,1,1,1 -> CS_R=3 until the 4th accepted beat, then 0.
- M1 reads 0x0003_0000 with ARLEN=2 and ARID=4'h5 -> AR_SEL=10, DS_ARREADY=1 in the same cycle, then Default_Slave. Expect 3 beats with DS_RRESP=11, DS_RID=5, DS_RLAST on the 3rd beat, then IDLE.
- ARREADY_S1 held low for 5 cycles in ReadAddr_M0 while ARVALID_M1 pulses -> CS_R stays 4, with no switch to M1.
- ARESET asserted mid-way through Default_Slave beat 2, asynchronously between edges -> CS_R=0, DS_RVALID=0 immediately. After release, a new M0 request is served normally.
